// File: rtl/phj_sched_pkg.sv
// phj_sched_pkg: shared scheduler state enum, default sizes and slot helper.
package phj_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  localparam int DEF_LANES = 8;
  localparam int DEF_SN_W = 32;
  function automatic int unsigned slot_of(input logic [31:0] sn, input int unsigned depth);
    return sn & (depth - 1);
  endfunction
endpackage

// File: rtl/sn_window_slot.sv
// sn_window_slot: per-batch lane completion bitmap with set, clear and all-set decode.
module sn_window_slot #(
  parameter int LANES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [LANES-1:0] set,
  output logic             all_set,
  output logic             dup
);
  logic [LANES-1:0] bits;
  assign all_set = &(bits | set);
  assign dup = |(bits & set);
  always_ff @(posedge clk)
    bits <= (reset || clr) ? '0 : bits | set;
endmodule

// File: rtl/probe_sn_scheduler.sv
// probe_sn_scheduler: in-order batch retire and window tracking for the probe phase.
// PROBE_SN_ERR_CHECK_EN enables range/duplicate/full-drop checks driving err.
module probe_sn_scheduler
  import phj_sched_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int MAX_IN_TRANSIT = 2,
  parameter int SN_W = DEF_SN_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       phase_start,
  input  logic                       issue_valid,
  input  logic                       last_issued,
  input  logic [LANES-1:0]           done_valid,
  input  logic [LANES-1:0][SN_W-1:0] done_sn,
  output logic [SN_W-1:0]            curr_sn,
  output logic [SN_W-1:0]            issued_cnt,
  output logic [SN_W-1:0]            in_transit,
  output logic                       window_full,
  output logic                       probe_done,
  output logic                       err
);
  localparam int D = MAX_IN_TRANSIT;
  localparam int SLW = D > 1 ? $clog2(D) : 1;
  state_e st;
  logic active, retire, issue_ok;
  logic [SLW-1:0] head;
  logic [D-1:0][LANES-1:0] set;
  logic [D-1:0] all_set, dup, clr;
  logic [LANES-1:0] legal, range_bad;
  assign in_transit = issued_cnt - curr_sn;
  assign window_full = in_transit == SN_W'(MAX_IN_TRANSIT);
  assign active = st == RUN || st == DRAIN;
  assign head = SLW'(slot_of(32'(curr_sn), D));
  assign retire = active && all_set[head];
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [SLW-1:0] sl;
    logic in_range;
    assign sl = SLW'(slot_of(32'(done_sn[i]), D));
    // wrap-safe: curr_sn <= sn < issued_cnt  <=>  (sn - curr_sn) < in_transit
    assign in_range = (done_sn[i] - curr_sn) < in_transit;
    assign range_bad[i] = active && done_valid[i] && !in_range;
`ifdef PROBE_SN_ERR_CHECK_EN
    assign legal[i] = active && done_valid[i] && in_range;
`else
    assign legal[i] = active && done_valid[i];
`endif
    for (genvar s = 0; s < D; s++) begin : g_set
      assign set[s][i] = legal[i] && sl == SLW'(s);
    end
  end
  for (genvar s = 0; s < D; s++) begin : g_slot
    assign clr[s] = phase_start || (retire && head == SLW'(s));
    sn_window_slot #(.LANES(LANES)) u_slot (
      .clk(clk), .reset(reset), .clr(clr[s]), .set(set[s]),
      .all_set(all_set[s]), .dup(dup[s])
    );
  end
`ifdef PROBE_SN_ERR_CHECK_EN
  assign issue_ok = st == RUN && issue_valid && !window_full;
  always_ff @(posedge clk)
    if (reset || phase_start) err <= 1'b0;
    else if (|dup || |range_bad || (st == RUN && issue_valid && window_full)) err <= 1'b1;
`else
  logic unused_chk;
  assign unused_chk = |dup | |range_bad;
  assign issue_ok = st == RUN && issue_valid;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      st <= IDLE;
      curr_sn <= '0;
      issued_cnt <= '0;
      probe_done <= 1'b0;
    end else if (phase_start) begin
      st <= RUN;
      curr_sn <= '0;
      issued_cnt <= '0;
      probe_done <= 1'b0;
    end else begin
      curr_sn <= curr_sn + SN_W'(retire);
      issued_cnt <= issued_cnt + SN_W'(issue_ok);
      if (st == RUN && last_issued) st <= DRAIN;
      if (st == DRAIN && in_transit == '0) begin
        st <= DONE;
        probe_done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_probe_sn_scheduler.sv
// tb_probe_sn_scheduler: directed scoreboard bench, SN_W=4 so serial numbers wrap quickly.
module tb_probe_sn_scheduler;
  localparam int LANES = 8;
  localparam int SN_W = 4;
`ifdef PROBE_SN_ERR_CHECK_EN
  localparam bit E = 1'b1;
`else
  localparam bit E = 1'b0;
`endif
  logic clk = 1'b0, reset, phase_start, issue_valid, last_issued;
  logic [LANES-1:0] done_valid;
  logic [LANES-1:0][SN_W-1:0] done_sn;
  logic [SN_W-1:0] curr_sn, issued_cnt, in_transit;
  logic window_full, probe_done, err;
  logic finished = 1'b0;
  typedef struct {
    string name;
    logic [14:0] v;
  } exp_t;
  exp_t q[$];
  int n_run = 0, n_fail = 0;

  probe_sn_scheduler #(.LANES(LANES), .MAX_IN_TRANSIT(2), .SN_W(SN_W)) dut (
    .clk(clk), .reset(reset), .phase_start(phase_start), .issue_valid(issue_valid),
    .last_issued(last_issued), .done_valid(done_valid), .done_sn(done_sn),
    .curr_sn(curr_sn), .issued_cnt(issued_cnt), .in_transit(in_transit),
    .window_full(window_full), .probe_done(probe_done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    while (q.size() != 0) begin
      exp_t e;
      logic [14:0] got;
      e = q.pop_front();
      got = {curr_sn, issued_cnt, in_transit, window_full, probe_done, err};
      n_run++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got curr=%0d iss=%0d it=%0d wf=%b pd=%b err=%b, want curr=%0d iss=%0d it=%0d wf=%b pd=%b err=%b",
                 e.name, got[14:11], got[10:7], got[6:3], got[2], got[1], got[0],
                 e.v[14:11], e.v[10:7], e.v[6:3], e.v[2], e.v[1], e.v[0]);
      end
    end

  initial begin
    #100000;
    n_run++;
    if (!finished) begin
      n_fail++;
      $display("FAIL timeout: stimulus did not complete");
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    phase_start = 0; issue_valid = 0; last_issued = 0; done_valid = '0;
  endtask

  task automatic chk(input string n, input logic [3:0] c, input logic [3:0] i,
                     input logic wf, input logic pd, input logic er);
    logic [3:0] it;
    it = i - c;
    q.push_back('{n, {c, i, it, wf, pd, er}});
  endtask

  task automatic done_all(input logic [3:0] sn);
    done_valid = '1;
    for (int l = 0; l < LANES; l++) done_sn[l] = sn;
  endtask

  task automatic done_lane(input int l, input logic [3:0] sn);
    done_valid[l] = 1'b1;
    done_sn[l] = sn;
  endtask

  initial begin
    reset = 1; phase_start = 0; issue_valid = 0; last_issued = 0;
    done_valid = '0; done_sn = '0;
    tick(); tick();
    reset = 0;
    n_run++;
    if ({curr_sn, issued_cnt, in_transit, window_full, probe_done, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_direct: curr=%0d iss=%0d it=%0d wf=%b pd=%b err=%b",
               curr_sn, issued_cnt, in_transit, window_full, probe_done, err);
    end
    chk("reset", 0, 0, 0, 0, 0);
    phase_start = 1; tick(); chk("start", 0, 0, 0, 0, 0);
    issue_valid = 1; tick(); chk("issue1", 0, 1, 0, 0, 0);
    done_all(0); tick(); chk("basic_retire", 1, 1, 0, 0, 0);
    phase_start = 1; tick();
    issue_valid = 1; tick();
    issue_valid = 1; tick(); chk("ooo_issued", 0, 2, 1, 0, 0);
    done_all(1); tick(); chk("ooo_sn1_first", 0, 2, 1, 0, 0);
    for (int l = 0; l < 7; l++) begin
      done_lane(l, 0); tick(); chk("ooo_partial", 0, 2, 1, 0, 0);
    end
    done_lane(7, 0); tick(); chk("ooo_retire0", 1, 2, 0, 0, 0);
    tick(); chk("ooo_retire1", 2, 2, 0, 0, 0);
    phase_start = 1; tick();
    issue_valid = 1; tick(); chk("wf_1", 0, 1, 0, 0, 0);
    issue_valid = 1; tick(); chk("wf_2", 0, 2, 1, 0, 0);
    issue_valid = 1; tick();
    if (E) chk("wf_drop", 0, 2, 1, 0, 1);
    else chk("wf_nodrop", 0, 3, 0, 0, 0);
    phase_start = 1; tick(); chk("err_clear", 0, 0, 0, 0, 0);
    issue_valid = 1; tick();
    issue_valid = 1; tick(); chk("rng_setup", 0, 2, 1, 0, 0);
    done_lane(3, 5); tick(); chk("rng_err", 0, 2, 1, 0, E);
    done_all(0); tick(); chk("rng_sn0", 1, 2, 0, 0, E);
    done_all(1); done_valid[3] = 1'b0; tick();
    chk("rng_bitmap", E ? 4'd1 : 4'd2, 2, 0, 0, E);
    tick(); chk("rng_bitmap_hold", E ? 4'd1 : 4'd2, 2, 0, 0, E);
    phase_start = 1; tick(); chk("dup_clear", 0, 0, 0, 0, 0);
    issue_valid = 1; tick();
    done_lane(2, 0); tick(); chk("dup_first", 0, 1, 0, 0, 0);
    done_lane(2, 0); tick(); chk("dup_second", 0, 1, 0, 0, E);
    phase_start = 1; tick();
    issue_valid = 1; tick();
    issue_valid = 1; tick(); chk("dr_full", 0, 2, 1, 0, 0);
    done_all(0); tick(); chk("dr_r0", 1, 2, 0, 0, 0);
    issue_valid = 1; done_all(1); tick(); chk("dr_issue_retire", 2, 3, 0, 0, 0);
    issue_valid = 1; last_issued = 1; tick(); chk("dr_last", 2, 4, 1, 0, 0);
    done_all(2); tick(); chk("dr_r2", 3, 4, 0, 0, 0);
    done_all(3); tick(); chk("dr_r3", 4, 4, 0, 0, 0);
    tick(); chk("dr_done", 4, 4, 0, 1, 0);
    issue_valid = 1; tick(); chk("done_ignore", 4, 4, 0, 1, 0);
    phase_start = 1; tick();
    for (int k = 0; k < 20; k++) begin
      logic [3:0] sn, nx;
      sn = 4'(k);
      nx = 4'(k + 1);
      issue_valid = 1; tick();
      done_all(sn); tick(); chk("wrap", nx, nx, 0, 0, 0);
    end
    issue_valid = 1; tick();
    last_issued = 1; tick(); chk("pre_reset", 4, 5, 0, 0, 0);
    reset = 1; tick(); reset = 0; chk("reset_drain", 0, 0, 0, 0, 0);
    issue_valid = 1; done_all(0); tick(); chk("idle_ignore", 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    finished = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
